// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out serializer:
// FSM state encodings and bit-order selector constants.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready load handshake.
// Reloads on the last bit when a new word is offered, giving gap-free streams.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             data_o,
  output logic             sval_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam bit SEND_MSB = (MSB_FIRST == piso_serializer_pkg::MSB_FIRST);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic busy;
  logic last;
  logic ready;
  logic accept;

  always_comb begin
    busy    = (state_q == ST_SHIFT);
    last    = busy & (cnt_q == CNT_LAST);
    ready   = !rst_i & (!busy | last);
    accept  = valid_i & ready;

    busy_o  = busy;
    sval_o  = busy;
    last_o  = last;
    ready_o = ready;
    data_o  = 1'b0;
    if (busy) begin
      data_o = SEND_MSB ? shift_q[WIDTH-1] : shift_q[0];
    end

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = data_i;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last) begin
          shift_d = SEND_MSB ? (shift_q << 1) : (shift_q >> 1);
          cnt_d   = cnt_q + 1'b1;
        end else if (accept) begin
          // Reload on the final bit so the next word follows with no idle cycle.
          shift_d = data_i;
          cnt_d   = '0;
        end else begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first 4-bit instance with a SIPO
// loopback receiver, plus an MSB-first 8-bit instance.
module tb_piso_serializer;

  logic       clk;
  logic       rst;

  logic [3:0] data4;
  logic       valid4;
  logic       ready4, d4, sval4, last4, busy4;

  logic [7:0] data8;
  logic       valid8;
  logic       ready8, d8, sval8, last8, busy8;

  logic [3:0] sipo;

  int vectors;
  int miscompares;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (data4),
    .valid_i (valid4),
    .ready_o (ready4),
    .data_o  (d4),
    .sval_o  (sval4),
    .last_o  (last4),
    .busy_o  (busy4)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut8 (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (data8),
    .valid_i (valid8),
    .ready_o (ready8),
    .data_o  (d8),
    .sval_o  (sval8),
    .last_o  (last8),
    .busy_o  (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback SIPO receiver: shifts in from the top, clocked only on valid bits.
  always @(posedge clk) begin
    if (rst) sipo <= 4'h0;
    else if (sval4) sipo <= {d4, sipo[3:1]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Send one word on the 4-bit instance with valid dropped after acceptance.
  task automatic applyStimulus(input logic [3:0] word, input logic [3:0] exp_bits);
    data4  = word;
    valid4 = 1'b1;
    #1;
    checkOutput("ready_idle", 32'(ready4), 32'd1);
    tick();
    valid4 = 1'b0;
    data4  = ~word;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bit%0d_data", i), 32'(d4), 32'(exp_bits[i]));
      checkOutput($sformatf("bit%0d_sval", i), 32'(sval4), 32'd1);
      checkOutput($sformatf("bit%0d_last", i), 32'(last4), 32'(i == 3));
      checkOutput($sformatf("bit%0d_ready", i), 32'(ready4), 32'(i == 3));
      tick();
    end
    checkOutput("idle_sval", 32'(sval4), 32'd0);
    checkOutput("idle_busy", 32'(busy4), 32'd0);
    checkOutput("idle_ready", 32'(ready4), 32'd1);
    checkOutput("idle_data", 32'(d4), 32'd0);
  endtask

  // Two words back to back with valid held high; checks stream and SIPO.
  task automatic applyPair(input logic [3:0] w0, input logic [3:0] w1,
                           input logic [7:0] exp_stream);
    data4  = w0;
    valid4 = 1'b1;
    tick();
    data4 = w1;
    #1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("b2b%0d_data", i), 32'(d4), 32'(exp_stream[i]));
      checkOutput($sformatf("b2b%0d_sval", i), 32'(sval4), 32'd1);
      checkOutput($sformatf("b2b%0d_last", i), 32'(last4), 32'(i == 3 || i == 7));
      if (i == 7) valid4 = 1'b0;
      tick();
      if (i == 3) checkOutput("sipo_word0", 32'(sipo), 32'(w0));
      if (i == 7) checkOutput("sipo_word1", 32'(sipo), 32'(w1));
    end
    checkOutput("b2b_end_sval", 32'(sval4), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    data4  = 4'h0;
    valid4 = 1'b0;
    data8  = 8'h00;
    valid8 = 1'b0;
    tick();
    tick();
    checkOutput("rst_data", 32'(d4), 32'd0);
    checkOutput("rst_sval", 32'(sval4), 32'd0);
    checkOutput("rst_last", 32'(last4), 32'd0);
    checkOutput("rst_busy", 32'(busy4), 32'd0);
    checkOutput("rst_ready", 32'(ready4), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_ready", 32'(ready4), 32'd1);

    $display("[TB] single word 4'b1011");
    applyStimulus(4'b1011, 4'b1011);

    $display("[TB] back-to-back 4'hA, 4'h5");
    applyPair(4'hA, 4'h5, 8'b0101_1010);

    $display("[TB] loopback 4'hB, 4'h6");
    applyPair(4'hB, 4'h6, 8'b0110_1011);

    $display("[TB] restart with 4'h3");
    applyStimulus(4'h3, 4'b0011);

    $display("[TB] reset mid-word");
    data4  = 4'hF;
    valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    #1;
    checkOutput("mid_bit0", 32'(d4), 32'd1);
    tick();
    checkOutput("mid_bit1", 32'(d4), 32'd1);
    tick();
    rst    = 1'b1;
    valid4 = 1'b1;
    data4  = 4'h9;
    #1;
    checkOutput("mid_ready_in_rst", 32'(ready4), 32'd0);
    tick();
    checkOutput("mid_rst_sval", 32'(sval4), 32'd0);
    checkOutput("mid_rst_data", 32'(d4), 32'd0);
    checkOutput("mid_rst_last", 32'(last4), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy4), 32'd0);
    checkOutput("mid_rst_ready", 32'(ready4), 32'd0);
    rst    = 1'b0;
    valid4 = 1'b0;
    #1;
    applyStimulus(4'h1, 4'b0001);

    $display("[TB] MSB-first 8-bit 8'hC5");
    data8  = 8'hC5;
    valid8 = 1'b1;
    #1;
    checkOutput("m8_ready_idle", 32'(ready8), 32'd1);
    tick();
    valid8 = 1'b0;
    data8  = 8'h00;
    #1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp8;
      exp8 = 8'b1010_0011;
      checkOutput($sformatf("m8_bit%0d_data", i), 32'(d8), 32'(exp8[i]));
      checkOutput($sformatf("m8_bit%0d_last", i), 32'(last8), 32'(i == 7));
      checkOutput($sformatf("m8_bit%0d_busy", i), 32'(busy8), 32'd1);
      tick();
    end
    checkOutput("m8_end_sval", 32'(sval8), 32'd0);
    checkOutput("m8_end_ready", 32'(ready8), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
4-bit-class parallel-in serial-out serializer with a valid/ready load handshake. It is the transmit-side counterpart of the existing serial-in parallel-out shift register. Default bit order is LSB first, so that after WIDTH serial-valid clocks the receiving SIPO holds the original word. Sits between a word-producing block and a single-wire serial link.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2
MSB_FIRST, 0, 0 = send bit 0 first (SIPO-compatible); 1 = send bit WIDTH-1 first

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
data_i  input  WIDTH  parallel word to serialize
valid_i  input  1  data_i valid; word accepted on a cycle with valid_i & ready_o
ready_o  output  1  serializer can accept a word this cycle
data_o  output  1  serial data bit
sval_o  output  1  data_o carries a valid bit this cycle
last_o  output  1  current bit is the final bit of the word
busy_o  output  1  word in flight (state SHIFT)

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Internal state: state_q {IDLE, SHIFT}, shift_q[WIDTH-1:0], cnt_q[$clog2(WIDTH)-1:0].
- Reset (rst_i high at an edge):
  - state_q=IDLE, shift_q=0, cnt_q=0.
  - Outputs after reset: data_o=0, sval_o=0, last_o=0, busy_o=0.
  - ready_o is forced 0 while rst_i is high; a handshake in that cycle is ignored.
- Output decode is combinational from registers:
  - sval_o = busy_o = (state_q==SHIFT).
  - data_o = shift_q[0] (LSB-first) or shift_q[WIDTH-1] (MSB-first) when in SHIFT, else 0.
  - last_o = SHIFT & (cnt_q==WIDTH-1).
  - ready_o = !rst_i & ((state_q==IDLE) | last_o).
- IDLE:
  - accept = valid_i & ready_o.
  - On accept: shift_q<=data_i, cnt_q<=0, state_q<=SHIFT.
  - Otherwise hold.
- SHIFT, not last:
  - LSB-first: shift_q<=shift_q>>1. MSB-first: shift_q<=shift_q<<1. Vacated bit fills with 0.
  - cnt_q<=cnt_q+1.
  - valid_i is ignored (ready_o=0).
- SHIFT, last:
  - If accept: reload shift_q<=data_i, cnt_q<=0, stay in SHIFT. This gives zero-gap back-to-back words.
  - Else: state_q<=IDLE, shift_q<=0, cnt_q<=0.
- Latency:
  - Word accepted at edge N: bit 0 of the stream is on data_o during cycle N+1.
  - The last bit is on data_o during cycle N+WIDTH.
  - Sustained throughput is one word per WIDTH cycles.
- Boundaries:
  - data_i changing after acceptance has no effect; the word is captured at accept.
  - valid_i held high in IDLE: word accepted immediately; next word accepted on the last bit.
  - rst_i asserted mid-word: the word is dropped, outputs return to reset values the next cycle, no partial completion. A valid_i present on the same cycle is not accepted.
  - cnt_q never exceeds WIDTH-1; no wrap-around beyond that.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=1'b0, ST_SHIFT=1'b1) and the bit-order constants (LSB_FIRST=0, MSB_FIRST=1).
- No sub-module; counter and shift register stay inline.
- The bench instantiates the existing SIPO as a loopback receiver.

Test Plan:
- WIDTH=4, load 4'b1011 at edge N.
  - Required: data_o=1,1,0,1 in cycles N+1..N+4; sval_o=1 for exactly those 4 cycles.
  - last_o only in N+4; ready_o=0 in N+1..N+3; ready_o=1 in N+4.
- Back-to-back: 4'hA, then 4'h5 presented with valid_i held high.
  - Required: 8 contiguous sval_o cycles, data_o=0,1,0,1,1,0,1,0.
  - last_o on cycles 4 and 8; no idle gap.
- Loopback: serializer data_o drives SIPO data_i, SIPO clocked only on sval_o cycles; send 4'hB and 4'h6.
  - Required: SIPO output = 4'hB after the 4th bit, then 4'h6 after the 8th.
- Return to idle: valid_i low during the last bit.
  - Required: the next cycle shows sval_o=0, busy_o=0, ready_o=1, data_o=0.
  - A later load of 4'h3 restarts from bit 0 (data_o=1,1,0,0).
- Reset mid-word: load 4'hF, assert rst_i after 2 bits.
  - Required: the cycle after reset shows sval_o=0, data_o=0, last_o=0, busy_o=0; ready_o=0 while rst_i is high.
  - After release, 4'h1 serializes as 1,0,0,0.
- MSB_FIRST=1, WIDTH=8, load 8'hC5.
  - Required: data_o=1,1,0,0,0,1,0,1; last_o on the 8th bit only.
